// File: rtl/fifo_accumulator.sv
// Drains VEC_LEN signed IL.FL words from a FIFO, sums them and offers the result on valid/ready.
// Define FIFO_ACC_SATURATE_EN to clamp the result to the word range instead of wrapping.
module fifo_accumulator #(
  parameter int unsigned IL           = 8,
  parameter int unsigned FL           = 12,
  parameter int unsigned IN_BUS_WIDTH = IL + FL,
  parameter int unsigned VEC_LEN      = 16,
  parameter int unsigned CNT_WIDTH    = $clog2(VEC_LEN + 1),
  parameter int unsigned ACC_WIDTH    = IN_BUS_WIDTH + $clog2(VEC_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    fifo_empty,
  input  logic [IN_BUS_WIDTH-1:0] fifo_data,
  output logic                    fifo_rd_en,
  output logic [IN_BUS_WIDTH-1:0] sum_out,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  localparam logic [CNT_WIDTH-1:0] VecLenC = CNT_WIDTH'(VEC_LEN);
  localparam logic [CNT_WIDTH-1:0] LastC   = CNT_WIDTH'(VEC_LEN - 1);

  state_e                       state;
  logic [CNT_WIDTH-1:0]         issued;
  logic [CNT_WIDTH-1:0]         received;
  logic                         rd_vld;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic [IN_BUS_WIDTH-1:0]      sum_conv;

  assign fifo_rd_en = (state == StRun) && !fifo_empty && (issued < VecLenC);
  assign busy       = (state != StIdle);
  assign acc_next   = acc + ACC_WIDTH'($signed(fifo_data));

`ifdef FIFO_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax = (ACC_WIDTH'(1) <<< (IN_BUS_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] AccMin = -AccMax - 1;

  always_comb begin
    if (acc_next > AccMax) begin
      sum_conv = {1'b0, {(IN_BUS_WIDTH - 1){1'b1}}};
    end else if (acc_next < AccMin) begin
      sum_conv = {1'b1, {(IN_BUS_WIDTH - 1){1'b0}}};
    end else begin
      sum_conv = acc_next[IN_BUS_WIDTH-1:0];
    end
  end
`else
  assign sum_conv = acc_next[IN_BUS_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      issued    <= '0;
      received  <= '0;
      rd_vld    <= 1'b0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      rd_vld <= fifo_rd_en;
      if (fifo_rd_en) begin
        issued <= issued + CNT_WIDTH'(1);
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            state    <= StRun;
            acc      <= '0;
            issued   <= '0;
            received <= '0;
          end
        end
        StRun: begin
          // Data arrives one cycle after its read; the last arrival closes the job.
          if (rd_vld) begin
            acc      <= acc_next;
            received <= received + CNT_WIDTH'(1);
            if (received == LastC) begin
              state     <= StOut;
              sum_out   <= sum_conv;
              sum_valid <= 1'b1;
            end
          end
        end
        StOut: begin
          if (sum_ready) begin
            state     <= StIdle;
            sum_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_accumulator.sv
// Directed bench for fifo_accumulator (VEC_LEN=4) with a behavioural registered-output FIFO.
module tb_fifo_accumulator;
  localparam int W = 20;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd_en;
  logic [W-1:0] sum_out;
  logic         sum_valid;
  logic         sum_ready = 1'b0;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int rd_count = 0;
  int bad_rd = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] pend[$];
  logic         flush_req = 1'b0;

  fifo_accumulator #(.VEC_LEN(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered data_out and empty, writes land one edge after being queued.
  always @(posedge clk) begin
    logic [W-1:0] w;
    if (fifo_rd_en) rd_count++;
    if (fifo_rd_en && fifo_empty) bad_rd++;
    if (flush_req) begin
      q.delete();
      pend.delete();
    end else begin
      if (fifo_rd_en && q.size() > 0) begin
        w = q.pop_front();
        fifo_data <= w;
      end
      while (pend.size() > 0) q.push_back(pend.pop_front());
    end
    fifo_empty <= (q.size() == 0);
  end

  task automatic push(input logic [W-1:0] w);
    pend.push_back(w);
  endtask

  task automatic flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
  endtask

  // Pulses start and returns the cycle index at which sum_valid is first seen (start cycle = 0).
  task automatic start_and_wait(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!sum_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    if (sum_out !== '0) begin errors++; $display("FAIL reset_sum_out got=%h exp=0", sum_out); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_job(input string name, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [W-1:0] w2, input logic [W-1:0] w3,
                         input logic [W-1:0] exp_sum);
    int lat;
    int rd0;
    push(w0); push(w1); push(w2); push(w3);
    repeat (2) @(negedge clk);
    rd0 = rd_count;
    sum_ready = 1'b1;
    start_and_wait(lat);
    checks += 2;
    if (lat != N + 2) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, N + 2); end
    if (sum_out !== exp_sum) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum_out, exp_sum); end
    @(negedge clk);
    sum_ready = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle busy=%b exp=0", name, busy); end
    if (rd_count - rd0 != N) begin errors++; $display("FAIL %s_reads got=%0d exp=%0d", name, rd_count - rd0, N); end
    if (fifo_empty !== 1'b1 || q.size() != 0) begin
      errors++; $display("FAIL %s_fifo_drained empty=%b left=%0d exp=1/0", name, fifo_empty, q.size());
    end
  endtask

  task automatic test_basic();
    run_job("basic", 20'h01000, 20'h02000, 20'h03000, 20'h04000, 20'h0A000);
  endtask

  task automatic test_signed();
    run_job("signed", 20'hFF000, 20'h00800, 20'hFE000, 20'h00000, 20'hFD800);
  endtask

  task automatic test_overflow();
`ifdef FIFO_ACC_SATURATE_EN
    run_job("overflow", 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
`else
    run_job("overflow", 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'hFFFFC);
`endif
  endtask

  task automatic test_empty_stall();
    int lat;
    int bad0;
    bad0 = bad_rd;
    push(20'h01000); push(20'h00800);
    repeat (2) @(negedge clk);
    sum_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks += 3;
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL stall_early_valid got=%b exp=0", sum_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", busy); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got=%b exp=0", fifo_rd_en); end
    push(20'h00400); push(20'h00200);
    lat = 0;
    while (!sum_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks += 3;
    if (!sum_valid) begin errors++; $display("FAIL stall_timeout waited=%0d exp<50", lat); end
    if (sum_out !== 20'h01E00) begin errors++; $display("FAIL stall_sum got=%h exp=01e00", sum_out); end
    if (bad_rd != bad0) begin errors++; $display("FAIL stall_read_while_empty got=%0d exp=0", bad_rd - bad0); end
    @(negedge clk);
    sum_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    int rd0;
    int bad_hold;
    logic [W-1:0] held;
    for (int i = 1; i <= 6; i++) push(W'(i * 'h100));
    repeat (2) @(negedge clk);
    rd0 = rd_count;
    sum_ready = 1'b0;
    start_and_wait(lat);
    held = sum_out;
    checks += 1;
    if (held !== 20'h00A00) begin errors++; $display("FAIL bp_sum got=%h exp=00a00", held); end
    bad_hold = 0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(negedge clk);
      if (sum_valid !== 1'b1 || sum_out !== 20'h00A00) bad_hold++;
    end
    checks += 1;
    if (bad_hold != 0) begin errors++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", bad_hold); end
    sum_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sum_ready = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored busy=%b exp=0", busy); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%b exp=0", sum_valid); end
    if (rd_count - rd0 != N) begin errors++; $display("FAIL bp_reads got=%0d exp=%0d", rd_count - rd0, N); end
    if (q.size() != 2) begin errors++; $display("FAIL bp_fifo_left got=%0d exp=2", q.size()); end
    repeat (2) @(negedge clk);
    checks += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queued_start busy=%b exp=0", busy); end
    flush();
  endtask

  task automatic test_reset_mid();
    int guard;
    push(20'h05000); push(20'h06000); push(20'h07000); push(20'h08000);
    repeat (2) @(negedge clk);
    rd_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (rd_count < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks += 4;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en got=%b exp=0", fifo_rd_en); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", sum_valid); end
    if (sum_out !== '0) begin errors++; $display("FAIL rst_mid_sum_out got=%h exp=0", sum_out); end
    reset = 1'b0;
    flush();
    run_job("post_reset", 20'h00010, 20'h00020, 20'h00030, 20'h00040, 20'h000A0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_empty_stall();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
